rom_fetch_buffer: RTL and testbench



---
 rtl/rom_fetch_buffer.sv | 114 +++++++++++
 tb/tb_rom_fetch_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_buffer.sv
// rom_fetch_buffer
//   Prefetch FIFO between the DW8051 program-fetch port and the combinational
//   program ROM. Sequential code bytes are streamed ahead of the CPU so that
//   in-order fetches complete in the same cycle. Any out-of-order fetch flushes
//   the buffer and restarts streaming at the requested address.
//
// Parameters
//   DEPTH      buffer entries, power of two, 2..16
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   cpu_rd     CPU fetch request for cpu_addr
//   cpu_addr   CPU fetch byte address
//   cpu_data   fetched byte, valid with cpu_ready
//   cpu_ready  fetch completes this cycle
//   rom_addr   ROM address (registered fetch pointer)
//   rom_cs_n   ROM chip select, active-low
//   rom_rd_n   ROM read strobe, active-low
//   rom_data   ROM data_out, combinational from rom_addr
//   hit_cnt    saturating HIT counter   (only with ROM_FETCH_STATS_EN)
//   miss_cnt   saturating MISS counter  (only with ROM_FETCH_STATS_EN)
//
// Build option
//   ROM_FETCH_STATS_EN  adds the hit/miss statistics counters and ports.
module rom_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic [15:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic        cpu_ready,
  output logic [15:0] rom_addr,
  output logic        rom_cs_n,
  output logic        rom_rd_n,
  input  logic [7:0]  rom_data
`ifdef ROM_FETCH_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   head_addr, fetch_addr;

  logic match, hit, miss, fill, push;

  assign match = (cpu_addr == head_addr);
  assign hit   = cpu_rd & match & (count != '0);
  assign miss  = cpu_rd & ~match;
  // Fill decision uses only registered count: a pop in a full cycle does not
  // open a slot until the next cycle.
  assign fill  = (count != FULL);
  // The byte read during a MISS cycle belongs to the abandoned stream.
  assign push  = fill & ~miss;

  assign rom_addr  = fetch_addr;
  // Strobes and handshake are forced idle while rst is held, including the
  // first reset cycle before the state registers have been cleared.
  assign rom_cs_n  = rst | ~fill;
  assign rom_rd_n  = rst | ~fill;
  assign cpu_ready = ~rst & hit;
  assign cpu_data  = (rst || count == '0) ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      head_addr  <= 16'h0000;
      fetch_addr <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (miss) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      head_addr  <= cpu_addr;
      fetch_addr <= cpu_addr;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rom_data;
        wr_ptr      <= wr_ptr + 1'b1;
        fetch_addr  <= fetch_addr + 16'h0001;
      end
      if (hit) begin
        rd_ptr    <= rd_ptr + 1'b1;
        head_addr <= head_addr + 16'h0001;
      end
      count <= count + CW'(push) - CW'(hit);
    end
  end

`ifdef ROM_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else begin
      if (hit  && hit_cnt  != 16'hFFFF) hit_cnt  <= hit_cnt  + 16'h0001;
      if (miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_rom_fetch_buffer.sv
// tb_rom_fetch_buffer
//   Directed bench for rom_fetch_buffer (DEPTH 4). A queue-based model of the
//   prefetch stream is checked against the DUT every cycle; directed steps add
//   hand-computed literal expectations for the documented scenarios.
module tb_rom_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ready;
  logic [15:0] rom_addr;
  logic        rom_cs_n;
  logic        rom_rd_n;
  logic [7:0]  rom_data;
`ifdef ROM_FETCH_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Program ROM image: a few fixed bytes, the rest a fixed address hash.
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h02;
      16'h0001: return 8'h00;
      16'h0002: return 8'h30;
      16'h0003: return 8'hE4;
      16'h1234: return 8'hAB;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  assign rom_data = rom_byte(rom_addr);

  rom_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .rom_addr(rom_addr), .rom_cs_n(rom_cs_n), .rom_rd_n(rom_rd_n),
    .rom_data(rom_data)
`ifdef ROM_FETCH_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue holding the bytes that must be buffered, starting at m_head.
  logic [7:0]  q[$];
  logic [15:0] m_head, m_fetch;
  bit          m_valid = 1'b0;
  bit          e_fill, e_hit, e_miss;
  logic [7:0]  dropped;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", {15'd0, cpu_ready}, 16'd0);
      chk("rst_cs_n",  {15'd0, rom_cs_n},  16'd1);
      chk("rst_rd_n",  {15'd0, rom_rd_n},  16'd1);
      chk("rst_data",  {8'd0, cpu_data},   16'd0);
      q.delete();
      m_head  = 16'h0000;
      m_fetch = 16'h0000;
      m_valid = 1'b1;
    end else if (m_valid) begin
      e_fill = (q.size() < DEPTH);
      e_hit  = cpu_rd && (cpu_addr == m_head) && (q.size() > 0);
      e_miss = cpu_rd && (cpu_addr != m_head);
      chk("m_ready",    {15'd0, cpu_ready}, {15'd0, e_hit});
      chk("m_rd_n",     {15'd0, rom_rd_n},  {15'd0, !e_fill});
      chk("m_cs_n",     {15'd0, rom_cs_n},  {15'd0, !e_fill});
      chk("m_rom_addr", rom_addr, m_fetch);
      if (e_hit) chk("m_data", {8'd0, cpu_data}, {8'd0, q[0]});
      if (e_miss) begin
        q.delete();
        m_head  = cpu_addr;
        m_fetch = cpu_addr;
      end else begin
        if (e_hit) begin
          dropped = q.pop_front();
          m_head  = m_head + 16'd1;
        end
        if (e_fill) begin
          q.push_back(rom_byte(m_fetch));
          m_fetch = m_fetch + 16'd1;
        end
      end
    end
  end

  // One cycle: drive inputs just after the edge, return at the following negedge.
  task automatic step(input logic r, input logic rd, input logic [15:0] a);
    @(posedge clk);
    #1;
    rst = r; cpu_rd = rd; cpu_addr = a;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cpu_rd = 1'b0; cpu_addr = 16'h0000;
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    chk("reset_cs_n",  {15'd0, rom_cs_n},  16'd1);
    chk("reset_ready", {15'd0, cpu_ready}, 16'd0);

    // Priming after reset: ROM reads at 0000..0003, then idle once full.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 16'h0000);
      chk("prime_addr", rom_addr, 16'(i));
      chk("prime_rd_n", {15'd0, rom_rd_n}, 16'd0);
    end
    step(0, 0, 16'h0000);
    chk("full_rd_n", {15'd0, rom_rd_n}, 16'd1);
    chk("full_addr", rom_addr, 16'h0004);

    // Sequential fetch from a full buffer: hit every cycle.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 16'(i));
      chk("seq_ready", {15'd0, cpu_ready}, 16'd1);
      chk("seq_data",  {8'd0, cpu_data}, {8'd0, rom_byte(16'(i))});
      if (i == 3) chk("seq_data_e4", {8'd0, cpu_data}, 16'h00E4);
    end
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);

    // Jump to 0x1234: two stall cycles, then AB, then 0x1235 hits.
    step(0, 1, 16'h1234);
    chk("jmp_miss", {15'd0, cpu_ready}, 16'd0);
    step(0, 1, 16'h1234);
    chk("jmp_wait", {15'd0, cpu_ready}, 16'd0);
    chk("jmp_rom_addr", rom_addr, 16'h1234);
    step(0, 1, 16'h1234);
    chk("jmp_ready", {15'd0, cpu_ready}, 16'd1);
    chk("jmp_data",  {8'd0, cpu_data}, 16'h00AB);
`ifdef ROM_FETCH_STATS_EN
    chk("jmp_miss_cnt", miss_cnt, 16'd1);
`endif
    step(0, 1, 16'h1235);
    chk("jmp_next", {15'd0, cpu_ready}, 16'd1);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);

    // Address wrap across 0xFFFF.
    step(0, 1, 16'hFFFE);
    chk("wrap_miss", {15'd0, cpu_ready}, 16'd0);
    step(0, 1, 16'hFFFE);
    chk("wrap_wait", {15'd0, cpu_ready}, 16'd0);
    step(0, 1, 16'hFFFE);
    chk("wrap_hit0", {15'd0, cpu_ready}, 16'd1);
    step(0, 1, 16'hFFFF);
    chk("wrap_hit1", {15'd0, cpu_ready}, 16'd1);
    chk("wrap_rom_addr", rom_addr, 16'h0000);
    step(0, 1, 16'h0000);
    chk("wrap_hit2", {15'd0, cpu_ready}, 16'd1);
    chk("wrap_data2", {8'd0, cpu_data}, 16'h0002);
    step(0, 1, 16'h0001);
    chk("wrap_hit3", {15'd0, cpu_ready}, 16'd1);

    // Let it fill, then a single HIT on a full buffer.
    for (int i = 0; i < 6; i++) step(0, 0, 16'h0000);
    chk("fp_full", {15'd0, rom_rd_n}, 16'd1);
    step(0, 1, 16'h0002);
    chk("fp_hit",      {15'd0, cpu_ready}, 16'd1);
    chk("fp_no_read",  {15'd0, rom_rd_n},  16'd1);
    step(0, 0, 16'h0000);
    chk("fp_one_read", {15'd0, rom_rd_n},  16'd0);
    step(0, 0, 16'h0000);
    chk("fp_refull",   {15'd0, rom_rd_n},  16'd1);

    // Reset in the middle of a fill (count 2, fetch_addr 0x0102).
    step(0, 1, 16'h0100);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    step(1, 0, 16'h0000);
    chk("mid_pre_addr", rom_addr, 16'h0102);
    chk("mid_cs_n",  {15'd0, rom_cs_n},  16'd1);
    chk("mid_ready", {15'd0, cpu_ready}, 16'd0);
    chk("mid_data",  {8'd0, cpu_data},   16'd0);
    step(0, 0, 16'h0000);
    chk("mid_restart_addr", rom_addr, 16'h0000);
    chk("mid_restart_rd_n", {15'd0, rom_rd_n}, 16'd0);
`ifdef ROM_FETCH_STATS_EN
    chk("mid_hit_cnt", hit_cnt, 16'd0);
`endif
    step(0, 1, 16'h0000);
    chk("mid_hit",  {15'd0, cpu_ready}, 16'd1);
    chk("mid_data0", {8'd0, cpu_data}, 16'h0002);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
